// File: rtl/fpu_issue_ctrl_if.sv
// Purpose: bundles the upstream push port, FPU issue/completion port and status of fpu_issue_ctrl.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the push side; the FPU side is strobe/pulse with no backpressure.
interface fpu_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_opcode;
  logic [31:0]   in_A;
  logic [31:0]   in_B;
  logic [3:0]    in_tag;
  logic          fpu_valid_in;
  logic [1:0]    fpu_opcode;
  logic [31:0]   fpu_A;
  logic [31:0]   fpu_B;
  logic          fpu_valid_out;
  logic          cmp_valid;
  logic [3:0]    cmp_tag;
  logic [1:0]    cmp_err;
  logic [CW-1:0] fifo_count;
  logic          busy;

  // Controller side
  modport master (
    input  in_valid, in_opcode, in_A, in_B, in_tag, fpu_valid_out,
    output in_ready, fpu_valid_in, fpu_opcode, fpu_A, fpu_B,
           cmp_valid, cmp_tag, cmp_err, fifo_count, busy
  );

  // Environment side (upstream producer, FPU and completion consumer)
  modport slave (
    output in_valid, in_opcode, in_A, in_B, in_tag, fpu_valid_out,
    input  in_ready, fpu_valid_in, fpu_opcode, fpu_A, fpu_B,
           cmp_valid, cmp_tag, cmp_err, fifo_count, busy
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Purpose: queues FP ops in a DEPTH-entry FIFO and issues them one at a time to an FPU, reporting completion/timeout.
// Latency: pop to issue strobe 1 cycle; completion pulse 1 cycle after fpu_valid_out, or TMO cycles after entering WAIT.
// Backpressure: in_ready drops when the FIFO is full, except in the cycle the head is popped; the FPU side has none.
module fpu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TMO   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  fpu_issue_ctrl_if.master  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_ILL    = 2'b01;
  localparam logic [1:0] ERR_TMO    = 2'b10;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [7:0]    tmo_cnt;
  logic [3:0]    pend_tag;

  logic          fpu_vld_q;
  logic [1:0]    fpu_op_q;
  logic [31:0]   fpu_a_q;
  logic [31:0]   fpu_b_q;
  logic          cmp_vld_q;
  logic [3:0]    cmp_tag_q;
  logic [1:0]    cmp_err_q;

  logic          in_ready;
  logic          push;
  logic          pop;
  entry_t        head;

  // The controller pops only from IDLE, and only when something is queued.
  assign pop  = (state == IDLE) && (count != '0);
  // A full FIFO still accepts in the cycle its head leaves, so the slot freed
  // by the pop is refilled on the same edge and occupancy stays at DEPTH.
  assign in_ready = (count < CW'(DEPTH)) || pop;
  assign push = bus.in_valid && in_ready;
  assign head = mem[rd_ptr];

  assign bus.in_ready     = in_ready;
  assign bus.fifo_count   = count;
  assign bus.busy         = (state != IDLE);
  assign bus.fpu_valid_in = fpu_vld_q;
  assign bus.fpu_opcode   = fpu_op_q;
  assign bus.fpu_A        = fpu_a_q;
  assign bus.fpu_B        = fpu_b_q;
  assign bus.cmp_valid    = cmp_vld_q;
  assign bus.cmp_tag      = cmp_tag_q;
  assign bus.cmp_err      = cmp_err_q;

  // Entry storage: written on accepted push, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: bus.in_opcode, a: bus.in_A, b: bus.in_B, tag: bus.in_tag};
    end
  end

  // Circular pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered issue/completion outputs; one op outstanding at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      pend_tag  <= '0;
      fpu_vld_q <= 1'b0;
      fpu_op_q  <= 2'b00;
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      cmp_vld_q <= 1'b0;
      cmp_tag_q <= '0;
      cmp_err_q <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head.opcode == OP_ILLEGAL) begin
              // Rejected without touching the FPU payload registers.
              cmp_vld_q <= 1'b1;
              cmp_tag_q <= head.tag;
              cmp_err_q <= ERR_ILL;
              state     <= DONE;
            end else begin
              fpu_vld_q <= 1'b1;
              fpu_op_q  <= head.opcode;
              fpu_a_q   <= head.a;
              fpu_b_q   <= head.b;
              pend_tag  <= head.tag;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          fpu_vld_q <= 1'b0;
          tmo_cnt   <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A response in the final counted cycle still wins over the timeout.
          if (bus.fpu_valid_out) begin
            cmp_vld_q <= 1'b1;
            cmp_tag_q <= pend_tag;
            cmp_err_q <= ERR_OK;
            state     <= DONE;
          end else if (tmo_cnt == 8'(TMO - 1)) begin
            cmp_vld_q <= 1'b1;
            cmp_tag_q <= pend_tag;
            cmp_err_q <= ERR_TMO;
            state     <= DONE;
          end
        end
        DONE: begin
          cmp_vld_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Purpose: self-checking bench for fpu_issue_ctrl with issue/completion scoreboards and a per-op FPU response model.
// Latency: checks issue spacing, completion latency relative to the issue strobe, and timeout distance.
// Backpressure: exercises full-FIFO rejection and the push-during-pop refill.
module tb_fpu_issue_ctrl;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          dly;
  } iss_t;

  typedef struct {
    logic [3:0] tag;
    logic [1:0] err;
    int         lat;
  } cmp_t;

  logic clk;
  logic rst_n;
  logic model_pulse;
  logic stray_pulse;

  int   checks;
  int   failures;
  int   cyc;
  int   resp_at;
  int   last_iss;

  iss_t iss_q[$];
  cmp_t cmp_q[$];

  fpu_issue_ctrl_if #(.DEPTH(4)) bus ();

  fpu_issue_ctrl #(.DEPTH(4), .TMO(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.fpu_valid_out = model_pulse | stray_pulse;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observes issue strobes and completions each negedge, and plays the FPU:
  // an op with dly>0 gets fpu_valid_out dly cycles after its issue cycle.
  task automatic monitor_loop();
    iss_t ei;
    cmp_t ec;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      model_pulse = (cyc == resp_at);
      if (!rst_n) begin
        last_iss    = -100;
        resp_at     = -1;
        model_pulse = 1'b0;
      end else begin
        if (bus.fpu_valid_in === 1'b1) begin
          checks++;
          if (cyc - last_iss < 4) begin
            failures++;
            $display("FAIL issue_spacing got=%0d cycles required>=4", cyc - last_iss);
          end
          checks++;
          if (iss_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_issue op=%b A=%h B=%h required=no issue", bus.fpu_opcode, bus.fpu_A, bus.fpu_B);
          end else begin
            ei = iss_q.pop_front();
            if ({bus.fpu_opcode, bus.fpu_A, bus.fpu_B} !== {ei.op, ei.a, ei.b}) begin
              failures++;
              $display("FAIL issue_payload got=%b/%h/%h required=%b/%h/%h",
                       bus.fpu_opcode, bus.fpu_A, bus.fpu_B, ei.op, ei.a, ei.b);
            end
            if (ei.dly != 0) resp_at = cyc + ei.dly;
          end
          last_iss = cyc;
        end
        if (bus.cmp_valid === 1'b1) begin
          checks++;
          if (cmp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_cmp tag=%0d err=%b required=no completion", bus.cmp_tag, bus.cmp_err);
          end else begin
            ec = cmp_q.pop_front();
            if ({bus.cmp_tag, bus.cmp_err} !== {ec.tag, ec.err}) begin
              failures++;
              $display("FAIL cmp_tag_err got=%0d/%b required=%0d/%b", bus.cmp_tag, bus.cmp_err, ec.tag, ec.err);
            end
            if (ec.lat != 0) begin
              checks++;
              if (cyc - last_iss != ec.lat) begin
                failures++;
                $display("FAIL cmp_latency tag=%0d got=%0d required=%0d", ec.tag, cyc - last_iss, ec.lat);
              end
            end
          end
        end
      end
    end
  endtask

  // Drives one push in the current cycle (caller is just past a negedge) and
  // records the expected issue/completion if the DUT accepts it.
  task automatic push_now(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input int dly, output bit acc);
    iss_t ei;
    cmp_t ec;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_A      = a;
    bus.in_B      = b;
    bus.in_tag    = tag;
    acc = (bus.in_ready === 1'b1);
    if (acc) begin
      ec.tag = tag;
      if (op == 2'b11) begin
        ec.err = 2'b01;
        ec.lat = 0;
      end else begin
        ei.op  = op;
        ei.a   = a;
        ei.b   = b;
        ei.dly = dly;
        iss_q.push_back(ei);
        ec.err = (dly == 0) ? 2'b10 : 2'b00;
        ec.lat = (dly == 0) ? 16 : dly + 1;
      end
      cmp_q.push_back(ec);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int dly, output bit acc);
    @(negedge clk);
    push_now(op, a, b, tag, dly, acc);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmp_q.size() == 0 && bus.busy === 1'b0 && bus.fifo_count === '0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_%s pending_cmp=%0d busy=%b count=%0d required=0/0/0",
               name, cmp_q.size(), bus.busy, bus.fifo_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.fifo_count, bus.fpu_valid_in, bus.cmp_valid, bus.cmp_err, bus.cmp_tag, bus.busy}
        !== {1'b1, 3'd0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ctrl got rdy=%b cnt=%0d fvi=%b cv=%b err=%b tag=%0d busy=%b required 1/0/0/0/00/0/0",
               bus.in_ready, bus.fifo_count, bus.fpu_valid_in, bus.cmp_valid, bus.cmp_err, bus.cmp_tag, bus.busy);
    end
    checks++;
    if ({bus.fpu_opcode, bus.fpu_A, bus.fpu_B} !== 66'd0) begin
      failures++;
      $display("FAIL reset_payload got=%b/%h/%h required=0", bus.fpu_opcode, bus.fpu_A, bus.fpu_B);
    end
  endtask

  task automatic test_basic();
    bit acc;
    // Release reset and push in the same cycle: the very first edge must accept.
    rst_n = 1'b1;
    push_now(2'b00, 32'h3F800000, 32'h40000000, 4'd5, 2, acc);
    checks++;
    if (!acc || bus.fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL first_push acc=%b count=%0d required=1/1", acc, bus.fifo_count);
    end
    wait_drain("basic");
    checks++;
    if ({bus.fpu_opcode, bus.fpu_A, bus.fpu_B} !== {2'b00, 32'h3F800000, 32'h40000000}) begin
      failures++;
      $display("FAIL payload_hold got=%b/%h/%h required=00/3f800000/40000000", bus.fpu_opcode, bus.fpu_A, bus.fpu_B);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_push(2'b01, 32'h11111111, 32'h22222222, 4'd1, 1, acc);
    do_push(2'b10, 32'h33333333, 32'h44444444, 4'd2, 15, acc);
    do_push(2'b00, 32'h55555555, 32'h66666666, 4'd3, 3, acc);
    wait_drain("back_to_back");
  endtask

  task automatic test_illegal();
    bit acc;
    do_push(2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 4'd9, 0, acc);
    do_push(2'b00, 32'h40400000, 32'h40800000, 4'd10, 2, acc);
    wait_drain("illegal");
  endtask

  task automatic test_timeout();
    bit acc;
    do_push(2'b10, 32'h3F000000, 32'h3E800000, 4'd3, 0, acc);
    do_push(2'b01, 32'h41200000, 32'h41A00000, 4'd4, 4, acc);
    wait_drain("timeout");
  endtask

  task automatic test_full_and_wrap();
    bit acc;
    bit idle_seen;
    // Blocker holds the controller in WAIT so the FIFO fills with no pops.
    do_push(2'b00, 32'h0000000F, 32'h000000F0, 4'd15, 0, acc);
    repeat (3) @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      do_push(2'b10, 32'h100 + t, 32'h200 + t, 4'(t), 0, acc);
      if (t == 3) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
          failures++;
          $display("FAIL full_ready rdy=%b count=%0d required=0/4", bus.in_ready, bus.fifo_count);
        end
      end
      if (t == 4) begin
        checks++;
        if (acc) begin
          failures++;
          $display("FAIL fifth_push accepted=%b required=0", acc);
        end
      end
    end
    idle_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        idle_seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!idle_seen) begin
      failures++;
      $display("FAIL full_idle_wait busy=%b required=0 within 40 cycles", bus.busy);
    end else begin
      push_now(2'b01, 32'h00000777, 32'h00000888, 4'd6, 0, acc);
      checks++;
      if (!acc || bus.fifo_count !== 3'd4) begin
        failures++;
        $display("FAIL push_on_pop acc=%b count=%0d required=1/4", acc, bus.fifo_count);
      end
    end
    wait_drain("full_wrap");
  endtask

  task automatic test_reset_in_wait();
    bit acc;
    do_push(2'b00, 32'hAAAA0000, 32'h0000AAAA, 4'd1, 0, acc);
    do_push(2'b00, 32'hBBBB0000, 32'h0000BBBB, 4'd2, 0, acc);
    do_push(2'b01, 32'hCCCC0000, 32'h0000CCCC, 4'd3, 0, acc);
    do_push(2'b10, 32'hDDDD0000, 32'h0000DDDD, 4'd4, 0, acc);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd3 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset count=%0d busy=%b required=3/1", bus.fifo_count, bus.busy);
    end
    rst_n = 1'b0;
    iss_q.delete();
    cmp_q.delete();
    #1;
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.cmp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d busy=%b rdy=%b cv=%b required=0/0/1/0",
               bus.fifo_count, bus.busy, bus.in_ready, bus.cmp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_pulse = 1'b1;
    @(negedge clk);
    stray_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cmp_valid !== 1'b0 || bus.fpu_valid_in !== 1'b0 || bus.fifo_count !== 3'd0) begin
        failures++;
        $display("FAIL post_reset_quiet cyc=%0d cv=%b fvi=%b count=%0d required=0/0/0",
                 i, bus.cmp_valid, bus.fpu_valid_in, bus.fifo_count);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    resp_at       = -1;
    last_iss      = -100;
    model_pulse   = 1'b0;
    stray_pulse   = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 2'b00;
    bus.in_A      = '0;
    bus.in_B      = '0;
    bus.in_tag    = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_full_and_wrap();
    test_reset_in_wait();
    checks++;
    if (iss_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_issues got=%0d required=0", iss_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
